alu_issue_ctrl: RTL and testbench

//  Initiator/sequencer for the 16-bit ALU: accepts one instruction at a time on a valid/ready port.

---
 rtl/alu_issue_ctrl_if.sv | 48 ++++
 rtl/alu_issue_ctrl.sv | 156 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Purpose: bundles the instruction port, ALU port, writeback, error and debug
//          signals of the ALU issue controller.
// Modports:
//   slave  - the controller (accepts instructions, drives the ALU)
//   master - the environment (instruction source, ALU, debug/observer)
`timescale 1ns/1ps
interface alu_issue_ctrl_if #(
  parameter int unsigned AW = 3
);
  // instruction port
  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    instr_op;
  logic [AW-1:0] instr_rd;
  logic [AW-1:0] instr_rs1;
  logic [AW-1:0] instr_rs2;
  logic [15:0]   instr_imm;
  // ALU port
  logic [2:0]    alu_control;
  logic          alu_load;
  logic [15:0]   alu_din_a;
  logic [15:0]   alu_din_b;
  logic          alu_valid_dout;
  logic [15:0]   alu_dout;
  // writeback observation
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [15:0]   wb_data;
  // error and debug
  logic          err;
  logic          err_clr;
  logic [AW-1:0] dbg_addr;
  logic [15:0]   dbg_data;

  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
    input  alu_valid_dout, alu_dout, err_clr, dbg_addr,
    output instr_ready, alu_control, alu_load, alu_din_a, alu_din_b,
    output wb_valid, wb_addr, wb_data, err, dbg_data
  );

  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
    output alu_valid_dout, alu_dout, err_clr, dbg_addr,
    input  instr_ready, alu_control, alu_load, alu_din_a, alu_din_b,
    input  wb_valid, wb_addr, wb_data, err, dbg_data
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Purpose: issues one instruction at a time to the 16-bit ALU. Operands come
//          from a local register file; the ALU result is written back to it.
//          LDI writes the register file directly without touching the ALU.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-high
//   bus   - alu_issue_ctrl_if.slave: instruction valid/ready port, ALU
//           control/operands/result, writeback pulse, sticky err with
//           err_clr, and a combinational debug read of the register file
`timescale 1ns/1ps
module alu_issue_ctrl #(
  parameter int unsigned NREGS   = 8,
  parameter int unsigned AW      = 3,
  parameter int unsigned TIMEOUT = 15
) (
  input logic             clk,
  input logic             reset,
  alu_issue_ctrl_if.slave bus
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 8;
  localparam logic [2:0]  OP_LDI = 3'b000;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [DW-1:0]   r_regs [NREGS];
  logic [AW-1:0]   r_rd;
  logic [CW-1:0]   r_cnt;
  logic            r_alu_load;
  logic [2:0]      r_alu_control;
  logic [DW-1:0]   r_din_a;
  logic [DW-1:0]   r_din_b;
  logic            r_wb_valid;
  logic [AW-1:0]   r_wb_addr;
  logic [DW-1:0]   r_wb_data;
  logic            r_err;

  logic [AW-1:0]   w_rd_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_load_nxt;
  logic [2:0]      w_ctrl_nxt;
  logic [DW-1:0]   w_din_a_nxt;
  logic [DW-1:0]   w_din_b_nxt;
  logic            w_wr_en;
  logic [AW-1:0]   w_wr_addr;
  logic [DW-1:0]   w_wr_data;
  logic            w_err_set;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and datapath control
  always_comb begin
    w_state_nxt = r_state;
    w_rd_nxt    = r_rd;
    w_cnt_nxt   = r_cnt;
    w_load_nxt  = 1'b0;
    w_ctrl_nxt  = r_alu_control;
    w_din_a_nxt = r_din_a;
    w_din_b_nxt = r_din_b;
    w_wr_en     = 1'b0;
    w_wr_addr   = '0;
    w_wr_data   = '0;
    w_err_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.instr_valid) begin
          if (bus.instr_op[2]) begin
            w_err_set = 1'b1;
          end else if (bus.instr_op == OP_LDI) begin
            w_wr_en   = 1'b1;
            w_wr_addr = bus.instr_rd;
            w_wr_data = bus.instr_imm;
          end else begin
            w_ctrl_nxt  = bus.instr_op;
            w_din_b_nxt = r_regs[bus.instr_rs1];
            w_din_a_nxt = r_regs[bus.instr_rs2];
            w_rd_nxt    = bus.instr_rd;
            w_load_nxt  = 1'b1;
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.alu_valid_dout) begin
          w_wr_en     = 1'b1;
          w_wr_addr   = r_rd;
          w_wr_data   = bus.alu_dout;
          w_state_nxt = S_IDLE;
        end else if ((r_cnt + CW'(1)) == CW'(TIMEOUT)) begin
          // Counter reaches TIMEOUT on the TIMEOUT-th empty WAIT cycle
          w_err_set   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath, register file and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) r_regs[i] <= '0;
      r_rd          <= '0;
      r_cnt         <= '0;
      r_alu_load    <= 1'b0;
      r_alu_control <= '0;
      r_din_a       <= '0;
      r_din_b       <= '0;
      r_wb_valid    <= 1'b0;
      r_wb_addr     <= '0;
      r_wb_data     <= '0;
      r_err         <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_regs[w_wr_addr] <= w_wr_data;
        r_wb_addr         <= w_wr_addr;
        r_wb_data         <= w_wr_data;
      end
      r_rd          <= w_rd_nxt;
      r_cnt         <= w_cnt_nxt;
      // alu_load is set on accept and held exactly through ISSUE
      r_alu_load    <= w_load_nxt;
      r_alu_control <= w_ctrl_nxt;
      r_din_a       <= w_din_a_nxt;
      r_din_b       <= w_din_b_nxt;
      r_wb_valid    <= w_wr_en;
      // A new error wins over a simultaneous clear
      r_err         <= w_err_set | (r_err & ~bus.err_clr);
    end
  end

  assign bus.instr_ready = (r_state == S_IDLE);
  assign bus.alu_load    = r_alu_load;
  assign bus.alu_control = r_alu_control;
  assign bus.alu_din_a   = r_din_a;
  assign bus.alu_din_b   = r_din_b;
  assign bus.wb_valid    = r_wb_valid;
  assign bus.wb_addr     = r_wb_addr;
  assign bus.wb_data     = r_wb_data;
  assign bus.err         = r_err;
  assign bus.dbg_data    = r_regs[bus.dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a transaction-level model (register array plus
// per-instruction latency rules) sets the expected outputs for each cycle and
// one negedge process compares them; a few literal checks pin the model.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;
  localparam int unsigned AW  = 3;
  localparam int unsigned TMO = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.AW(AW)) bus();

  alu_issue_ctrl #(.NREGS(8), .AW(AW), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ALU responder: result one cycle after alu_load
  logic        rsp_en;
  logic        rsp_valid = 1'b0;
  logic [15:0] rsp_dout  = 16'h0;
  logic        force_valid;
  assign bus.alu_valid_dout = rsp_valid | force_valid;
  assign bus.alu_dout       = force_valid ? 16'hBEEF : rsp_dout;

  always @(posedge clk) begin
    rsp_valid <= rsp_en & bus.alu_load;
    case (bus.alu_control)
      3'b001:  rsp_dout <= bus.alu_din_b + bus.alu_din_a;
      3'b010:  rsp_dout <= bus.alu_din_b - bus.alu_din_a;
      3'b011:  rsp_dout <= 16'(bus.alu_din_b * bus.alu_din_a);
      default: rsp_dout <= 16'h0;
    endcase
  end

  // Model state and expected outputs
  logic [15:0] m_regs [8];
  logic        e_ready, e_load, e_wb_valid, e_err;
  logic [2:0]  e_ctrl;
  logic [15:0] e_a, e_b, e_wb_data;
  logic [2:0]  e_wb_addr;
  bit          chk_en;
  int          total, bad, cyc_tb;
  logic [2:0]  s_ctrl;
  logic [15:0] s_a, s_b, s_wb_data;
  logic [2:0]  s_wb_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("instr_ready", 32'(bus.instr_ready), 32'(e_ready));
      chk("alu_load",    32'(bus.alu_load),    32'(e_load));
      if (e_load) begin
        chk("alu_control", 32'(bus.alu_control), 32'(e_ctrl));
        chk("alu_din_a",   32'(bus.alu_din_a),   32'(e_a));
        chk("alu_din_b",   32'(bus.alu_din_b),   32'(e_b));
      end
      chk("wb_valid", 32'(bus.wb_valid), 32'(e_wb_valid));
      chk("wb_addr",  32'(bus.wb_addr),  32'(e_wb_addr));
      chk("wb_data",  32'(bus.wb_data),  32'(e_wb_data));
      chk("err",      32'(bus.err),      32'(e_err));
      chk("dbg_data", 32'(bus.dbg_data), 32'(m_regs[bus.dbg_addr]));
    end
  end

  task automatic set_reset_expect();
    e_ready = 1'b1; e_load = 1'b0; e_wb_valid = 1'b0; e_err = 1'b0;
    e_wb_addr = '0; e_wb_data = '0; e_ctrl = '0; e_a = '0; e_b = '0;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
  endtask

  // Advance one cycle; pulse expectations fall back, err_clr takes effect
  task automatic tick();
    logic clr;
    clr = bus.err_clr;
    @(posedge clk);
    #1;
    cyc_tb++;
    e_load     = 1'b0;
    e_wb_valid = 1'b0;
    if (clr) e_err = 1'b0;
    bus.dbg_addr = 3'(cyc_tb);
  endtask

  task automatic dbg_chk(input string name, input logic [2:0] addr, input logic [15:0] exp);
    bus.dbg_addr = addr;
    #0.25;
    chk(name, 32'(bus.dbg_data), 32'(exp));
  endtask

  // Present one instruction while idle and follow it to completion
  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [15:0] imm);
    logic [15:0] a, b, res;
    bus.instr_valid = 1'b1;
    bus.instr_op = op; bus.instr_rd = rd; bus.instr_rs1 = rs1;
    bus.instr_rs2 = rs2; bus.instr_imm = imm;
    a = m_regs[rs2];
    b = m_regs[rs1];
    tick();
    bus.instr_valid = 1'b0;
    bus.instr_op = 3'b111; bus.instr_imm = 16'hDEAD;
    if (op[2]) begin
      e_err = 1'b1;
    end else if (op == 3'b000) begin
      m_regs[rd] = imm;
      e_wb_valid = 1'b1; e_wb_addr = rd; e_wb_data = imm;
    end else begin
      case (op)
        3'b001:  res = 16'((32'(b) + 32'(a)) & 32'hFFFF);
        3'b010:  res = 16'((32'(b) + 32'h10000 - 32'(a)) & 32'hFFFF);
        default: res = 16'((32'(b) * 32'(a)) & 32'hFFFF);
      endcase
      e_ready = 1'b0; e_load = 1'b1; e_ctrl = op; e_a = a; e_b = b;
      #1;
      s_ctrl = bus.alu_control; s_a = bus.alu_din_a; s_b = bus.alu_din_b;
      tick();
      if (rsp_en) begin
        tick();
        m_regs[rd] = res;
        e_wb_valid = 1'b1; e_wb_addr = rd; e_wb_data = res; e_ready = 1'b1;
        #1;
        s_wb_addr = bus.wb_addr; s_wb_data = bus.wb_data;
      end else begin
        for (int i = 1; i < int'(TMO); i++) tick();
        tick();
        e_ready = 1'b1; e_err = 1'b1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before t=200000");
    $fatal(1);
  end

  initial begin
    total = 0; bad = 0; cyc_tb = 0; chk_en = 1'b0;
    reset = 1'b1; rsp_en = 1'b1; force_valid = 1'b0;
    bus.instr_valid = 1'b0; bus.instr_op = '0; bus.instr_rd = '0;
    bus.instr_rs1 = '0; bus.instr_rs2 = '0; bus.instr_imm = '0;
    bus.err_clr = 1'b0; bus.dbg_addr = '0;
    set_reset_expect();

    // 1: reset state
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_alu_control", 32'(bus.alu_control), 32'h0);
    chk("rst_din_a", 32'(bus.alu_din_a), 32'h0);
    chk("rst_din_b", 32'(bus.alu_din_b), 32'h0);
    for (int i = 0; i < 8; i++) dbg_chk("rst_dbg", 3'(i), 16'h0);
    reset = 1'b0;
    tick();

    // 2: LDI, LDI, ADD
    issue(3'b000, 3'd1, 3'd0, 3'd0, 16'h0005);
    issue(3'b000, 3'd2, 3'd0, 3'd0, 16'h0003);
    issue(3'b001, 3'd3, 3'd1, 3'd2, 16'h0000);
    chk("t2_din_b",    32'(s_b),       32'h0005);
    chk("t2_din_a",    32'(s_a),       32'h0003);
    chk("t2_control",  32'(s_ctrl),    32'h1);
    chk("t2_wb_addr",  32'(s_wb_addr), 32'h3);
    chk("t2_wb_data",  32'(s_wb_data), 32'h0008);
    tick();

    // 3: SUB wrap, MUL overflow, self-add, nonzero MUL low bits
    issue(3'b010, 3'd4, 3'd2, 3'd1, 16'h0000);
    issue(3'b000, 3'd6, 3'd0, 3'd0, 16'h0100);
    issue(3'b011, 3'd5, 3'd6, 3'd6, 16'h0000);
    issue(3'b001, 3'd7, 3'd7, 3'd7, 16'h0000);
    issue(3'b011, 3'd0, 3'd4, 3'd2, 16'h0000);
    tick();
    dbg_chk("t3_r4", 3'd4, 16'hFFFE);
    dbg_chk("t3_r5", 3'd5, 16'h0000);
    dbg_chk("t3_r6", 3'd6, 16'h0100);
    dbg_chk("t3_r0", 3'd0, 16'hFFFA);
    tick();

    // 4: illegal ops, clear racing a new error, clear alone, stray valid in IDLE
    issue(3'b101, 3'd1, 3'd1, 3'd1, 16'h1111);
    bus.err_clr = 1'b1;
    issue(3'b110, 3'd2, 3'd2, 3'd2, 16'h2222);
    bus.err_clr = 1'b0;
    tick();
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    force_valid = 1'b1;
    tick();
    force_valid = 1'b0;
    tick();
    chk("t4_err_cleared", 32'(bus.err), 32'h0);
    dbg_chk("t4_r1_kept", 3'd1, 16'h0005);

    // 5: ALU never answers -> timeout
    rsp_en = 1'b0;
    issue(3'b001, 3'd3, 3'd4, 3'd4, 16'h0000);
    rsp_en = 1'b1;
    chk("t5_err", 32'(bus.err), 32'h1);
    dbg_chk("t5_r3_kept", 3'd3, 16'h0008);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    issue(3'b001, 3'd2, 3'd2, 3'd1, 16'h0000);
    tick();

    // 6: reset while in WAIT, stale valid right after
    rsp_en = 1'b0;
    bus.instr_valid = 1'b1; bus.instr_op = 3'b001;
    bus.instr_rd = 3'd6; bus.instr_rs1 = 3'd1; bus.instr_rs2 = 3'd2;
    e_a = m_regs[2]; e_b = m_regs[1];
    tick();
    bus.instr_valid = 1'b0;
    e_ready = 1'b0; e_load = 1'b1; e_ctrl = 3'b001;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    force_valid = 1'b1;
    set_reset_expect();
    tick();
    force_valid = 1'b0;
    tick();
    dbg_chk("t6_r6", 3'd6, 16'h0);
    dbg_chk("t6_r1", 3'd1, 16'h0);
    chk("t6_ready", 32'(bus.instr_ready), 32'h1);
    rsp_en = 1'b1;
    tick();
    issue(3'b000, 3'd2, 3'd0, 3'd0, 16'h00AA);
    tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
